trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences all machine-mode trap entry/exit traffic into the CSR file through its single write port.
//  - Arbitrates commit-stage exception, mret and async interrupts (sw/timer/ext); stalls the pipeline while sequencing.
//  - Issues ordered writes to mepc/mcause/mtval, then one mstatus/priv update pulse, then flush + PC redirect.
//  - Sits between the commit (M) stage, the CSR file and fetch redirect logic.
// PARAMETERS
//  XLEN       64   data/PC width
//  CSR_AW     12   CSR address width
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  commit_valid   in   1      M-stage instruction valid this cycle
//  commit_pc      in   XLEN   M-stage instruction PC
//  commit_exc     in   1      M-stage instruction raised synchronous exception
//  commit_cause   in   4      exception code (csr_pkg MCAUSE_*)
//  commit_tval    in   XLEN   faulting address/instr for mtval
//  commit_mret    in   1      M-stage instruction is mret
//  irq_sw/irq_tm/irq_ext in 1 level interrupt lines (mip bits 3/7/11)
//  mstatus_mie    in   1      current mstatus.MIE
//  mie_csr        in   XLEN   current mie CSR
//  priv           in   2      current privilege mode
//  mtvec          in   XLEN   current mtvec (bits[1:0] = mode)
//  mepc           in   XLEN   current mepc
//  irq_epc        in   XLEN   PC of oldest unretired instruction (interrupt return PC)
//  pipe_idle      in   1      no outstanding memory op; trap may be accepted
//  busy           out  1      stall request to whole pipeline
//  csr_we         out  1      CSR write strobe
//  csr_waddr      out  CSR_AW CSR write address
//  csr_wdata      out  XLEN   CSR write data
//  status_enter   out  1      1-cycle pulse: MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M
//  status_exit    out  1      1-cycle pulse: MIE<=MPIE, MPIE<=1, priv<=MPP, MPP<=U
//  redirect_valid out  1      1-cycle pulse: flush all stages, fetch from redirect_pc
//  redirect_pc    out  XLEN   redirect target
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; latched cause/epc/tval/target cleared. Reset mid-sequence aborts immediately; no partial-write recovery.
//  - Moore outputs: decoded from state + latched regs only; no input->output combinational path.
//  - Acceptance only in IDLE with pipe_idle=1. Priority: commit_exc (needs commit_valid) > commit_mret (needs commit_valid) > interrupt.
//  - Interrupt enabled iff (priv!=M || mstatus_mie) && mip&mie_csr bit set; priority ext(11) > sw(3) > tm(7).
//  - On accept latch: epc (commit_pc, or irq_epc for irq), cause (irq: bit XLEN-1 set | code), tval (commit_tval, 0 for irq), target.
//  - Target: trap -> mtvec&~3; vectored (mtvec[1:0]==1) AND irq -> (mtvec&~3)+4*code; mret -> mepc sampled at accept.
//  - Trap states, one cycle each: W_EPC(we,0x341,epc) -> W_CAUSE(we,0x342,cause) -> W_TVAL(we,0x343,tval) -> STATUS(status_enter) -> REDIRECT -> IDLE.
//  - Mret states: STATUS(status_exit) -> REDIRECT -> IDLE.
//  - REDIRECT: redirect_valid=1, redirect_pc=target. Trap latency accept->redirect = 5 cycles; mret = 2.
//  - busy = (state!=IDLE). All inputs ignored outside IDLE; irq deassert or new exception mid-sequence has no effect.
//  - Irq pending while pipe_idle=0: held off (level lines, no latching); exception with pipe_idle=0: held off until idle.
//  - Back-to-back: IDLE is re-entered for >=1 cycle between sequences; a pending irq after mret is accepted from IDLE.
//  - csr_waddr/csr_wdata = 0 whenever csr_we=0.
// STRUCTURE
//  - csr_pkg: add trap_state_t {IDLE,W_EPC,W_CAUSE,W_TVAL,STATUS,REDIRECT}; reuse CSR_MEPC/MCAUSE/MTVAL, MCAUSE_* codes, MCAUSE_INTERRUPT_MASK, PRIV_*.
//  - Sub-module irq_arbiter (combinational): enable check + fixed priority -> irq_take, irq_code[3:0].
// TESTING
//  1. Illegal instr, pc=0x8000_0010, mtvec=0x8000_1000 -> writes mepc=0x8000_0010, mcause=2, mtval=tval, enter pulse; redirect 0x8000_1000 at cycle 5.
//  2. mret, mepc=0x8000_0024 -> status_exit at cycle 1, redirect 0x8000_0024 at cycle 2; no csr_we.
//  3. irq_tm=1, mie[7]=1, MIE=1, mtvec=0x8000_1001 -> mcause=0x8000_0000_0000_0007; redirect 0x8000_101C.
//  4. irq_ext+irq_sw+ecall-M (cause 11) same cycle -> exception wins: mcause=11; ext irq accepted after return to IDLE if still enabled.
//  5. priv=M, MIE=0, irq_sw=1 -> no accept, busy stays 0; priv=U -> accepted, mcause LSBs=3.
//  6. pipe_idle=0 with exception -> busy 0, no writes until pipe_idle=1; reset asserted in W_CAUSE -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, cause codes, privilege encodings and trap sequencer states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [3:0] MCAUSE_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] MCAUSE_BREAKPOINT    = 4'd3;
  localparam logic [3:0] MCAUSE_LOAD_FAULT    = 4'd5;
  localparam logic [3:0] MCAUSE_ECALL_M       = 4'd11;
  localparam logic [3:0] MCAUSE_M_SW_IRQ      = 4'd3;
  localparam logic [3:0] MCAUSE_M_TIMER_IRQ   = 4'd7;
  localparam logic [3:0] MCAUSE_M_EXT_IRQ     = 4'd11;

  localparam logic [63:0] MCAUSE_INTERRUPT_MASK = 64'h8000_0000_0000_0000;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    STATUS,
    REDIRECT
  } trap_state_t;

endpackage

// File: rtl/trap_sequencer_irq_arbiter.sv
// Machine interrupt enable check and fixed-priority pick: ext > sw > timer.
module irq_arbiter
  import csr_pkg::*;
(
  input  logic       irq_sw,
  input  logic       irq_tm,
  input  logic       irq_ext,
  input  logic       mie_sw,
  input  logic       mie_tm,
  input  logic       mie_ext,
  input  logic       mstatus_mie,
  input  logic [1:0] priv,
  output logic       irq_take,
  output logic [3:0] irq_code
);

  logic global_en;

  // Below M-mode, machine interrupts are taken regardless of MIE.
  assign global_en = (priv != PRIV_M) || mstatus_mie;

  always_comb begin
    irq_take = 1'b0;
    irq_code = 4'd0;
    if (global_en) begin
      if (irq_ext && mie_ext) begin
        irq_take = 1'b1;
        irq_code = MCAUSE_M_EXT_IRQ;
      end else if (irq_sw && mie_sw) begin
        irq_take = 1'b1;
        irq_code = MCAUSE_M_SW_IRQ;
      end else if (irq_tm && mie_tm) begin
        irq_take = 1'b1;
        irq_code = MCAUSE_M_TIMER_IRQ;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: serialises mepc/mcause/mtval writes,
// the mstatus/priv pulse and the final flush + redirect through one CSR write port.
module trap_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic              commit_exc,
  input  logic [3:0]        commit_cause,
  input  logic [XLEN-1:0]   commit_tval,
  input  logic              commit_mret,
  input  logic              irq_sw,
  input  logic              irq_tm,
  input  logic              irq_ext,
  input  logic              mstatus_mie,
  input  logic [XLEN-1:0]   mie_csr,
  input  logic [1:0]        priv,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  input  logic [XLEN-1:0]   irq_epc,
  input  logic              pipe_idle,
  output logic              busy,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              status_enter,
  output logic              status_exit,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  trap_state_t     state;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] target_q;

  logic            irq_take;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] irq_target;
  logic [XLEN-1:0] irq_cause;
  logic            unused_mie;

  irq_arbiter u_irq_arbiter (
    .irq_sw      (irq_sw),
    .irq_tm      (irq_tm),
    .irq_ext     (irq_ext),
    .mie_sw      (mie_csr[3]),
    .mie_tm      (mie_csr[7]),
    .mie_ext     (mie_csr[11]),
    .mstatus_mie (mstatus_mie),
    .priv        (priv),
    .irq_take    (irq_take),
    .irq_code    (irq_code)
  );

  assign unused_mie = ^{mie_csr[XLEN-1:12], mie_csr[10:8], mie_csr[6:4], mie_csr[2:0]};

  // Vectored mode only offsets interrupts; synchronous exceptions always use the base.
  assign tvec_base  = {mtvec[XLEN-1:2], 2'b00};
  assign irq_target = (mtvec[1:0] == 2'b01) ? tvec_base + XLEN'({irq_code, 2'b00}) : tvec_base;
  assign irq_cause  = XLEN'(MCAUSE_INTERRUPT_MASK >> (64 - XLEN)) | XLEN'(irq_code);

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cause_q        <= '0;
      tval_q         <= '0;
      target_q       <= '0;
      busy           <= 1'b0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      status_enter   <= 1'b0;
      status_exit    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      status_enter   <= 1'b0;
      status_exit    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (pipe_idle) begin
            if (commit_valid && commit_exc) begin
              state     <= W_EPC;
              busy      <= 1'b1;
              cause_q   <= XLEN'(commit_cause);
              tval_q    <= commit_tval;
              target_q  <= tvec_base;
              csr_we    <= 1'b1;
              csr_waddr <= CSR_AW'(CSR_MEPC);
              csr_wdata <= commit_pc;
            end else if (commit_valid && commit_mret) begin
              state       <= STATUS;
              busy        <= 1'b1;
              target_q    <= mepc;
              status_exit <= 1'b1;
            end else if (irq_take) begin
              state     <= W_EPC;
              busy      <= 1'b1;
              cause_q   <= irq_cause;
              tval_q    <= '0;
              target_q  <= irq_target;
              csr_we    <= 1'b1;
              csr_waddr <= CSR_AW'(CSR_MEPC);
              csr_wdata <= irq_epc;
            end
          end
        end
        W_EPC: begin
          state     <= W_CAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= CSR_AW'(CSR_MCAUSE);
          csr_wdata <= cause_q;
        end
        W_CAUSE: begin
          state     <= W_TVAL;
          csr_we    <= 1'b1;
          csr_waddr <= CSR_AW'(CSR_MTVAL);
          csr_wdata <= tval_q;
        end
        W_TVAL: begin
          state        <= STATUS;
          status_enter <= 1'b1;
        end
        STATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= target_q;
        end
        REDIRECT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exception, mret, interrupts, priority, hold-off and reset abort.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_exc;
  logic [3:0]  commit_cause;
  logic [63:0] commit_tval;
  logic        commit_mret;
  logic        irq_sw, irq_tm, irq_ext;
  logic        mstatus_mie;
  logic [63:0] mie_csr;
  logic [1:0]  priv;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [63:0] irq_epc;
  logic        pipe_idle;
  logic        busy;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        status_enter;
  logic        status_exit;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.XLEN(64), .CSR_AW(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_exc     (commit_exc),
    .commit_cause   (commit_cause),
    .commit_tval    (commit_tval),
    .commit_mret    (commit_mret),
    .irq_sw         (irq_sw),
    .irq_tm         (irq_tm),
    .irq_ext        (irq_ext),
    .mstatus_mie    (mstatus_mie),
    .mie_csr        (mie_csr),
    .priv           (priv),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .irq_epc        (irq_epc),
    .pipe_idle      (pipe_idle),
    .busy           (busy),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .status_enter   (status_enter),
    .status_exit    (status_exit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    commit_valid = 1'b0;
    commit_exc   = 1'b0;
    commit_mret  = 1'b0;
  endtask

  // Entered 1 time unit after the accept edge; leaves the bench 1 cycle into IDLE.
  task automatic check_trap(input string tag, input logic [63:0] epc, input logic [63:0] cause,
                            input logic [63:0] tval, input logic [63:0] target);
    chk({tag, "_epc_we"}, csr_we, 1);
    chk({tag, "_epc_addr"}, csr_waddr, 12'h341);
    chk({tag, "_epc_data"}, csr_wdata, epc);
    chk({tag, "_busy"}, busy, 1);
    tick();
    chk({tag, "_cause_addr"}, csr_waddr, 12'h342);
    chk({tag, "_cause_data"}, csr_wdata, cause);
    tick();
    chk({tag, "_tval_addr"}, csr_waddr, 12'h343);
    chk({tag, "_tval_data"}, csr_wdata, tval);
    tick();
    chk({tag, "_enter"}, status_enter, 1);
    chk({tag, "_exit0"}, status_exit, 0);
    chk({tag, "_we0"}, csr_we, 0);
    chk({tag, "_addr0"}, csr_waddr, 0);
    chk({tag, "_data0"}, csr_wdata, 0);
    chk({tag, "_noredir"}, redirect_valid, 0);
    tick();
    chk({tag, "_redir"}, redirect_valid, 1);
    chk({tag, "_redir_pc"}, redirect_pc, target);
    chk({tag, "_enter_off"}, status_enter, 0);
    chk({tag, "_busy_redir"}, busy, 1);
    tick();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_redir"}, redirect_valid, 0);
  endtask

  initial begin
    reset        = 1'b1;
    clear_commit();
    commit_pc    = '0;
    commit_cause = '0;
    commit_tval  = '0;
    irq_sw       = 1'b0;
    irq_tm       = 1'b0;
    irq_ext      = 1'b0;
    mstatus_mie  = 1'b0;
    mie_csr      = '0;
    priv         = 2'b11;
    mtvec        = 64'h8000_1000;
    mepc         = '0;
    irq_epc      = '0;
    pipe_idle    = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_we", csr_we, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Illegal instruction, direct mtvec
    commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 4'd2;
    commit_pc = 64'h8000_0010; commit_tval = 64'h0000_0000_DEAD_BEEF;
    tick();
    clear_commit();
    check_trap("illegal", 64'h8000_0010, 64'd2, 64'h0000_0000_DEAD_BEEF, 64'h8000_1000);

    // mret
    mepc = 64'h8000_0024;
    commit_valid = 1'b1; commit_mret = 1'b1; commit_pc = 64'h8000_0100;
    tick();
    clear_commit();
    chk("mret_exit", status_exit, 1);
    chk("mret_enter", status_enter, 0);
    chk("mret_we", csr_we, 0);
    chk("mret_busy", busy, 1);
    tick();
    chk("mret_redir", redirect_valid, 1);
    chk("mret_redir_pc", redirect_pc, 64'h8000_0024);
    chk("mret_we2", csr_we, 0);
    tick();
    chk("mret_idle", busy, 0);

    // Timer interrupt, vectored mtvec
    irq_tm = 1'b1; mie_csr = 64'h80; mstatus_mie = 1'b1; priv = 2'b11;
    mtvec = 64'h8000_1001; irq_epc = 64'h8000_0040;
    tick();
    irq_tm = 1'b0;
    check_trap("tmirq", 64'h8000_0040, 64'h8000_0000_0000_0007, 64'd0, 64'h8000_101C);

    // Exception beats ext+sw interrupts; ext taken once back in IDLE
    mtvec = 64'h8000_1000; mie_csr = 64'h808; irq_ext = 1'b1; irq_sw = 1'b1;
    irq_epc = 64'h8000_0200;
    commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 4'd11;
    commit_pc = 64'h8000_0050; commit_tval = 64'd0;
    tick();
    clear_commit();
    check_trap("ecall", 64'h8000_0050, 64'd11, 64'd0, 64'h8000_1000);
    tick();
    irq_ext = 1'b0; irq_sw = 1'b0;
    check_trap("extirq", 64'h8000_0200, 64'h8000_0000_0000_000B, 64'd0, 64'h8000_1000);

    // Globally masked in M-mode, taken from U-mode
    priv = 2'b11; mstatus_mie = 1'b0; irq_sw = 1'b1; mie_csr = 64'h8;
    mtvec = 64'h8000_1001; irq_epc = 64'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("masked_busy", busy, 0);
      chk("masked_we", csr_we, 0);
    end
    priv = 2'b00;
    tick();
    irq_sw = 1'b0;
    check_trap("swirq_u", 64'h0000_1000, 64'h8000_0000_0000_0003, 64'd0, 64'h8000_100C);

    // Hold-off while pipe busy, then reset abort mid-sequence
    priv = 2'b11; mstatus_mie = 1'b1; mie_csr = 64'h80; irq_tm = 1'b1;
    pipe_idle = 1'b0;
    commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 4'd5;
    commit_pc = 64'h8000_0300; commit_tval = 64'h9000_0008;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("holdoff_busy", busy, 0);
      chk("holdoff_we", csr_we, 0);
    end
    irq_tm = 1'b0;
    pipe_idle = 1'b1;
    tick();
    clear_commit();
    chk("late_epc_we", csr_we, 1);
    chk("late_epc_data", csr_wdata, 64'h8000_0300);
    tick();
    chk("late_cause_data", csr_wdata, 64'd5);
    reset = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_we", csr_we, 0);
    chk("abort_addr", csr_waddr, 0);
    chk("abort_data", csr_wdata, 0);
    chk("abort_enter", status_enter, 0);
    chk("abort_redir", redirect_valid, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("post_abort_busy", busy, 0);
    chk("post_abort_we", csr_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
